// File: rtl/execute_stage_if.sv
// EX-stage bus: ID-side request (valid/ready) and EX/MEM result register toward MEM.
// The stage uses the slave modport; the surrounding pipeline (or a bench) uses master.
interface execute_stage_if #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_op;
  logic             use_sign;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [4:0]       shamt;
  logic [REGW-1:0]  dest_in;
  logic             reg_write_in;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic [REGW-1:0]  dest_out;
  logic             reg_write_out;

  modport slave (
    input  in_valid, alu_op, use_sign, operand_a, operand_b, shamt,
           dest_in, reg_write_in, flush, out_ready,
    output in_ready, out_valid, result, zero, overflow, dest_out, reg_write_out
  );

  modport master (
    output in_valid, alu_op, use_sign, operand_a, operand_b, shamt,
           dest_in, reg_write_in, flush, out_ready,
    input  in_ready, out_valid, result, zero, overflow, dest_out, reg_write_out
  );
endinterface

// File: rtl/execute_stage.sv
// Registered MIPS EX stage: ALU with zero/signed-overflow flags feeding a one-entry
// EX/MEM register with valid/ready handshake, backpressure stall and flush.
module execute_stage #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input logic          clk,
  input logic          rst_n,
  execute_stage_if.slave ex
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_NOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;
  logic [REGW-1:0]  dest_q, dest_d;
  logic             reg_write_q, reg_write_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             less;
  logic             accept;

  assign sum  = ex.operand_a + ex.operand_b;
  assign diff = ex.operand_a - ex.operand_b;
  assign less = ex.use_sign ? ($signed(ex.operand_a) < $signed(ex.operand_b))
                            : (ex.operand_a < ex.operand_b);

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (ex.alu_op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = ex.use_sign && (ex.operand_a[WIDTH-1] == ex.operand_b[WIDTH-1])
                  && (sum[WIDTH-1] != ex.operand_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = ex.use_sign && (ex.operand_a[WIDTH-1] != ex.operand_b[WIDTH-1])
                  && (diff[WIDTH-1] != ex.operand_a[WIDTH-1]);
      end
      OP_AND: alu_res = ex.operand_a & ex.operand_b;
      OP_OR:  alu_res = ex.operand_a | ex.operand_b;
      OP_NOR: alu_res = ~(ex.operand_a | ex.operand_b);
      OP_SLL: alu_res = ex.operand_b << ex.shamt;
      OP_SRL: alu_res = ex.operand_b >> ex.shamt;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, less};
      default: begin
        alu_res = '0;
        alu_ovf = 1'b0;
      end
    endcase
  end

  // No skid buffer: accepting while full is only possible when MEM drains the same edge.
  assign ex.in_ready = !valid_q || ex.out_ready;
  assign accept      = ex.in_valid && ex.in_ready && !ex.flush;

  always_comb begin
    valid_d     = valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    overflow_d  = overflow_q;
    dest_d      = dest_q;
    reg_write_d = reg_write_q;
    if (ex.flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
    end else if (accept) begin
      valid_d     = 1'b1;
      result_d    = alu_res;
      zero_d      = (alu_res == '0);
      overflow_d  = alu_ovf;
      dest_d      = ex.dest_in;
      reg_write_d = ex.reg_write_in && !alu_ovf;
    end else if (ex.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      dest_q      <= '0;
      reg_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
      dest_q      <= dest_d;
      reg_write_q <= reg_write_d;
    end
  end

  assign ex.out_valid     = valid_q;
  assign ex.result        = result_q;
  assign ex.zero          = zero_q;
  assign ex.overflow      = overflow_q;
  assign ex.dest_out      = dest_q;
  assign ex.reg_write_out = reg_write_q;

endmodule

// File: tb/tb_execute_stage.sv
// Randomized and directed bench for execute_stage against an arithmetic reference model.
module tb_execute_stage;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   n_done;

  execute_stage_if #(.WIDTH(32), .REGW(5)) bus ();

  execute_stage #(.WIDTH(32), .REGW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ex    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state of the EX/MEM register.
  logic        m_valid;
  logic [31:0] m_result;
  logic        m_zero;
  logic        m_ovf;
  logic [4:0]  m_dest;
  logic        m_rw;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  function automatic void ref_alu(input logic [3:0] op, input logic us,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] sh,
                                  output logic [31:0] r, output logic ov);
    longint sa, sb, s, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    r  = 32'd0;
    ov = 1'b0;
    case (op)
      4'd0: begin s = sa + sb; r = 32'(ua + ub); ov = us && (s > 64'sd2147483647 || s < -64'sd2147483648); end
      4'd1: begin s = sa - sb; r = 32'(ua - ub); ov = us && (s > 64'sd2147483647 || s < -64'sd2147483648); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = ~(a | b);
      4'd5: r = 32'(ub * (longint'(1) << sh));
      4'd6: r = 32'(ub / (longint'(1) << sh));
      4'd7: r = (us ? (sa < sb) : (ua < ub)) ? 32'd1 : 32'd0;
      default: begin r = 32'd0; ov = 1'b0; end
    endcase
  endfunction

  task automatic drive(input logic v, input logic [3:0] op, input logic us,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                       input logic [4:0] d, input logic rw, input logic fl, input logic rdy);
    bus.in_valid     = v;
    bus.alu_op       = op;
    bus.use_sign     = us;
    bus.operand_a    = a;
    bus.operand_b    = b;
    bus.shamt        = sh;
    bus.dest_in      = d;
    bus.reg_write_in = rw;
    bus.flush        = fl;
    bus.out_ready    = rdy;
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_result = 32'd0; m_zero = 1'b0;
    m_ovf = 1'b0; m_dest = 5'd0; m_rw = 1'b0;
  endtask

  // One clock: check in_ready, advance the model across the edge, check the register.
  task automatic tick();
    logic        exp_ready, acc, ov, drained;
    logic [31:0] r;
    #1;
    exp_ready = !m_valid || bus.out_ready;
    check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ready});
    acc = bus.in_valid && exp_ready && !bus.flush;
    drained = m_valid && bus.out_ready;
    ref_alu(bus.alu_op, bus.use_sign, bus.operand_a, bus.operand_b, bus.shamt, r, ov);
    if (acc)
      $display("txn op=%0d us=%0b a=%h b=%h sh=%0d dest=%0d -> res=%h ovf=%0b",
               bus.alu_op, bus.use_sign, bus.operand_a, bus.operand_b, bus.shamt,
               bus.dest_in, r, ov);
    @(posedge clk);
    if (drained) n_done++;
    if (bus.flush) begin
      m_valid = 1'b0;
      m_rw    = 1'b0;
    end else if (acc) begin
      m_valid = 1'b1; m_result = r; m_zero = (r == 32'd0); m_ovf = ov;
      m_dest = bus.dest_in; m_rw = bus.reg_write_in && !ov;
    end else if (bus.out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
    if (m_valid || !m_rw)
      check("reg_write_out", {31'd0, bus.reg_write_out}, {31'd0, m_rw});
    if (m_valid) begin
      check("result", bus.result, m_result);
      check("zero", {31'd0, bus.zero}, {31'd0, m_zero});
      check("overflow", {31'd0, bus.overflow}, {31'd0, m_ovf});
      check("dest_out", {27'd0, bus.dest_out}, {27'd0, m_dest});
    end
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'h7FFFFFFF;
      1: v = 32'h80000000;
      2: v = 32'hFFFFFFFF;
      3: v = 32'd0;
      default: v = $urandom();
    endcase
    return v;
  endfunction

  initial begin
    int start_done;
    logic [31:0] ra, rb;
    n_checks = 0;
    n_fail   = 0;
    n_done   = 0;
    model_reset();
    drive(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_rw", {31'd0, bus.reg_write_out}, 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Signed add overflow, then the same without signed trap.
    drive(1'b1, 4'd0, 1'b1, 32'h7FFFFFFF, 32'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1);
    tick();
    check("ovf_result", bus.result, 32'h80000000);
    check("ovf_flag", {31'd0, bus.overflow}, 32'd1);
    check("ovf_rw", {31'd0, bus.reg_write_out}, 32'd0);
    check("ovf_dest", {27'd0, bus.dest_out}, 32'd5);
    drive(1'b1, 4'd0, 1'b0, 32'h7FFFFFFF, 32'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1);
    tick();
    check("novf_flag", {31'd0, bus.overflow}, 32'd0);
    check("novf_rw", {31'd0, bus.reg_write_out}, 32'd1);

    // SLT signedness, sub to zero, shifts.
    drive(1'b1, 4'd7, 1'b1, 32'hFFFFFFFF, 32'd1, 5'd0, 5'd1, 1'b1, 1'b0, 1'b1);
    tick();
    check("slt_signed", bus.result, 32'd1);
    drive(1'b1, 4'd7, 1'b0, 32'hFFFFFFFF, 32'd1, 5'd0, 5'd1, 1'b1, 1'b0, 1'b1);
    tick();
    check("slt_unsigned", bus.result, 32'd0);
    drive(1'b1, 4'd1, 1'b1, 32'h1234, 32'h1234, 5'd0, 5'd2, 1'b1, 1'b0, 1'b1);
    tick();
    check("sub_zero_res", bus.result, 32'd0);
    check("sub_zero_flag", {31'd0, bus.zero}, 32'd1);
    drive(1'b1, 4'd5, 1'b0, 32'd0, 32'h0000ABCD, 5'd16, 5'd3, 1'b1, 1'b0, 1'b1);
    tick();
    check("lui", bus.result, 32'hABCD0000);
    drive(1'b1, 4'd6, 1'b0, 32'd0, 32'h80000000, 5'd31, 5'd3, 1'b1, 1'b0, 1'b1);
    tick();
    check("srl31", bus.result, 32'd1);

    // Backpressure: three stalled cycles, then a 4-op stream at full rate.
    drive(1'b1, 4'd2, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
    repeat (3) begin
      tick();
      check("stall_ready", {31'd0, bus.in_ready}, 32'd0);
      check("stall_result", bus.result, 32'd1);
    end
    start_done = n_done;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'd0, 1'b0, 32'd100 * i, 32'd1, 5'd0, 5'(10 + i), 1'b1, 1'b0, 1'b1);
      tick();
      check("stream_result", bus.result, 32'd100 * i + 32'd1);
    end
    check("stream_drained", n_done - start_done, 32'd4);

    // Flush while full with a concurrent input.
    drive(1'b1, 4'd3, 1'b0, 32'h11, 32'h22, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0);
    tick();
    check("flush_valid", {31'd0, bus.out_valid}, 32'd0);
    check("flush_rw", {31'd0, bus.reg_write_out}, 32'd0);
    drive(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    check("flush_gone", {31'd0, bus.out_valid}, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      ra = rand_operand();
      rb = rand_operand();
      drive(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 1'($urandom()),
            ra, rb, 5'($urandom()), 5'($urandom()), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 2) != 0));
      tick();
    end

    // Asynchronous reset mid-hold drops the entry without a clock edge.
    drive(1'b1, 4'd3, 1'b0, 32'h5, 32'hA, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("arst_rw", {31'd0, bus.reg_write_out}, 32'd0);
    check("arst_result", bus.result, 32'd0);
    model_reset();
    #1 rst_n = 1'b1;
    drive(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Registered EX stage of the pipelined MIPS CPU, directly downstream of ALUControlUnit.
- Takes the decoded aluOp/useSign pair plus operands from the ID side and computes the ALU result, zero flag and signed-overflow flag.
- Holds the result in a one-entry EX/MEM output register with a valid/ready handshake toward MEM.
- Supports pipeline stall via backpressure and flush on branch redirect.

Parameters:
- WIDTH, 32, datapath width of operands and result.
- REGW, 5, width of destination register index.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  ID side presents a valid operation.
- in_ready  output  1  stage can accept an operation this cycle.
- alu_op  input  4  operation code from ALUControlUnit: 0 add, 1 sub, 2 and, 3 or, 4 nor, 5 sll, 6 srl, 7 slt; 8–15 undefined.
- use_sign  input  1  from ALUControlUnit: signed overflow trap for add/sub; signed compare for slt.
- operand_a  input  WIDTH  rs value.
- operand_b  input  WIDTH  rt value or extended immediate.
- shamt  input  5  shift amount (instr[10:6]; ID drives 16 for LUI).
- dest_in  input  REGW  destination register index.
- reg_write_in  input  1  operation writes the register file.
- flush  input  1  discard the held result and any input this cycle.
- out_valid  output  1  EX/MEM register holds a valid result.
- out_ready  input  1  MEM accepts the result this cycle.
- result  output  WIDTH  registered ALU result.
- zero  output  1  registered (result == 0).
- overflow  output  1  registered signed-overflow flag.
- dest_out  output  REGW  registered destination index.
- reg_write_out  output  1  registered write enable, gated by overflow.

Behaviour:
- Reset (async, rst_n=0): out_valid, result, zero, overflow, dest_out, reg_write_out all 0, effective immediately. A reset in mid-operation drops the held entry.
- in_ready = !out_valid || out_ready. This is combinational; there is no skid buffer.
- Accept when in_valid && in_ready && !flush. The output register loads on that clock edge, so latency is 1 cycle.
- Hold: out_valid && !out_ready leaves all outputs unchanged. Inputs are ignored because in_ready=0.
- Drain: out_valid && out_ready && !accept clears out_valid on the next edge. Data regs may hold stale values.
- Simultaneous drain and accept: a new entry replaces the old one in the same edge, giving back-to-back throughput of 1 per cycle.
- Flush is highest priority: on the next edge out_valid=0 and reg_write_out=0, and a concurrent input is discarded.
- Arithmetic, with a and b as operands:
  - add: a+b mod 2^WIDTH.
  - sub: a−b mod 2^WIDTH.
  - and, or: bitwise.
  - nor: ~(a|b).
  - sll: b << shamt.
  - srl: b >> shamt, logical.
  - slt: {0…,1} if a<b, else 0. The compare is signed when use_sign=1, unsigned otherwise.
  - alu_op 8–15: result 0, overflow 0.
- Overflow is set only when use_sign=1 and the op is add/sub with signed overflow:
  - add: sign(a)==sign(b) and sign(sum)!=sign(a).
  - sub: sign(a)!=sign(b) and sign(diff)!=sign(a).
- On overflow, reg_write_out=0 and result still holds the wrapped value. Otherwise reg_write_out=reg_write_in.
- zero reflects the full-width result, including slt and undefined ops. Branches (sub) use it.
- dest_out captures dest_in on accept.

Test Plan:
- Reset: assert rst_n=0 mid-hold with out_valid=1 → out_valid, reg_write_out and result drop to 0 without waiting for a clock edge.
- Signed add overflow: op=0, use_sign=1, a=32'h7FFFFFFF, b=1, reg_write_in=1, dest=5 → next cycle result=32'h80000000, overflow=1, reg_write_out=0, dest_out=5. The same inputs with use_sign=0 give overflow=0, reg_write_out=1.
- SLT signedness: a=32'hFFFFFFFF, b=1 → op 7, use_sign=1 gives result=1; use_sign=0 gives result=0. Also sub with a=b=32'h1234 gives result=0, zero=1.
- Shift/LUI: op=5, b=32'h0000ABCD, shamt=16 → result=32'hABCD0000. Then op=6, b=32'h80000000, shamt=31 → result=1.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs stable. Release out_ready → a new entry loads on the same edge the old one drains, and a 4-op stream completes in 4 consecutive cycles.
- Flush: flush=1 with in_valid=1 and out_valid=1 → next cycle out_valid=0 and reg_write_out=0. The flushed input never appears on the output.
